tm_mem_req_issuer: RTL and testbench
====================================

# tm_mem_req_issuer

Per-thread miss-issue timing model that drives the DRAM timing model's request interface. It sits between the cache timing model and the DRAM timing model. For every thread token it produces one `tm_mem_request_t` token: a new request on a cache miss, otherwise a poll token. It reads back `stay_stalled_for_dram` to decide when a missing thread is released. It also keeps miss, writeback and stall statistics for the debug path.

## Interface
Parameters:
- `NT`, default `NTHREAD`: number of hardware threads, and the depth of the state RAM.
- `STATW`, default `32`: width of each statistics counter.

Ports:
- `gclk`, in, `iu_clk_type`: all logic uses `gclk.clk` rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `tok_valid`, in, 1: a thread token is present this cycle.
- `tok_tid`, in, `NTHREADIDMSB+1`: thread id of the token.
- `miss_valid`, in, 1: the token carries a cache miss.
- `miss_dirty`, in, 1: the victim line is dirty, so a writeback is needed.
- `miss_addr`, in, 32: line address of the miss.
- `dram_request`, out, `tm_mem_request_t`: request token to the DRAM model.
- `stay_stalled_for_dram`, in, 1: DRAM model's stall bit, already indexed by `dram_request.tid`.
- `resp_valid`, out, 1: response is valid for `resp_tid`.
- `resp_tid`, out, `NTHREADIDMSB+1`: thread id of the response.
- `resp_stall`, out, 1: the thread must replay this target cycle.
- `init_busy`, out, 1: the state-RAM clear sweep is in progress.
- `proto_err`, out, 1: sticky protocol-error flag.
- `stat_miss`, out, `STATW`: count of issued misses.
- `stat_wb`, out, `STATW`: count of issued writebacks.
- `stat_stall`, out, `STATW`: count of tokens answered with `resp_stall=1`.

## Operation
Per-thread state is held in a `select_ram` of `NT` entries. Each entry is a 2-bit `mrq_state_t` plus a wait counter of `log2x(MAX_MISS_PENALTY)` bits.

- **Stage 1.** The token is registered: `tok_valid`, `tok_tid`, `miss_valid`, `miss_dirty`, `miss_addr`.
- **Stage 2, combinational.** The state RAM is read at the registered tid. `dram_request` is driven and the response is computed from that state.
- **Stage 2, commit.** The state RAM write happens at the clock edge that ends stage 2.

State transitions (applied to the Stage 2 token):
- **IDLE, no miss:**
  - drive `token_valid=1`, `request_valid=0`, `writeback_valid=0`;
  - respond `resp_stall=0`.
- **IDLE, miss:**
  - drive `request_valid=1`, `writeback_valid=miss_dirty`, `request_addr=miss_addr`;
  - go to WAIT and clear the wait counter;
  - respond `resp_stall=1`;
  - increment `stat_miss`, and increment `stat_wb` when `miss_dirty=1`.
- **WAIT:**
  - drive `request_valid=0`;
  - if `stay_stalled_for_dram=1`: stay in WAIT, increment the wait counter (saturating), respond `resp_stall=1`;
  - if `stay_stalled_for_dram=0`: go to IDLE and respond `resp_stall=0`. This is the release token: the thread proceeds.
- **WAIT with `miss_valid=1`:** this is illegal. The miss is ignored, `proto_err` is set, and the WAIT rules above still apply.
- **Wait counter reaches `MAX_MISS_PENALTY-1` in WAIT:** `proto_err` is set. This is the lost-release watchdog. The state stays in WAIT.
- **`stat_stall`** increments on every response with `resp_stall=1`.
- **All statistics counters** wrap modulo 2^`STATW`.

## Timing
- **Reset values** while `rst_n=0`:
  - pipeline valid bits and `dram_request` are all zeros;
  - `resp_*` outputs are 0;
  - statistics counters and `proto_err` are 0;
  - `init_busy=1`.
- **Init sweep** after `rst_n` rises:
  - one RAM entry is written to IDLE per cycle, tid 0 through `NT-1`;
  - `init_busy` falls on the cycle after the last write, so it is high for exactly `NT` cycles;
  - any `tok_valid` during the sweep is dropped and sets `proto_err`.
- **Latency.** A token presented at cycle t drives `dram_request` and `resp_*` during cycle t+1. This is a 1-cycle registered latency.
- **Same-tid hazard.**
  - Back-to-back tokens for the same tid (the single-thread case) must see the state written by the previous token.
  - This is handled by forwarding the stage-2 write data into the stage-2 read when the tids match.
- **Mid-operation reset.** When `rst_n` falls, everything clears immediately and the init sweep restarts.
- **Stall bit timing.** The DRAM model sets its stall bit on the request token. The earliest possible release therefore comes on the next token for that tid.

## Structure
- **Shared package (`libtm_cache`):**
  - `mrq_state_t` (IDLE, WAIT);
  - the RAM entry struct;
  - the constant `MRQ_WAIT_W = log2x(MAX_MISS_PENALTY)`.
- **`tm_mem_request_t` and `MAX_MISS_PENALTY`** are reused from `libtm` and are not redefined.
- **Sub-module `mrq_state_ram`:**
  - single write port and asynchronous read;
  - carries the `syn_ramstyle="select_ram"` attribute;
  - contains the init-sweep address counter.

## Test plan
1. **Reset and init.** With `NT=4`, release `rst_n` → `init_busy` is high for 4 cycles, all outputs are 0, and all RAM entries read IDLE.
2. **Clean miss.** Tid 2 misses at `0x1000` with `miss_dirty=0` → the next cycle shows `request_valid=1`, `writeback_valid=0`, `request_addr=0x1000`. The stub holds `stay_stalled_for_dram=1` for 3 further tid-2 tokens → `resp_stall=1` on each of them, then 0 on the release token. Expect `stat_miss=1`, `stat_stall=4`.
3. **Dirty miss.** `miss_dirty=1` → `writeback_valid=1` and `stat_wb=1`.
4. **Single-thread back-to-back.** Tid 0 miss followed by a tid-0 token on the very next cycle → the second token sees WAIT through forwarding, not IDLE.
5. **Illegal and lost release.**
   - A miss on a thread already in WAIT → `proto_err=1` and no new request is issued.
   - A separate run that holds stall at 1 for `MAX_MISS_PENALTY` tokens → `proto_err=1`.
6. **Reset mid-WAIT.** Drop `rst_n` while tid 1 is in WAIT → the init sweep reruns and the next tid-1 token answers `resp_stall=0`.

Source files
------------

// File: rtl/tm_mem_req_issuer_pkg.sv
// Shared timing-model types: libtm supplies global thread/request definitions,
// libtm_cache adds the miss-issuer per-thread state.
package libtm;
  localparam int NTHREAD          = 4;
  localparam int NTHREADIDMSB     = 1;
  localparam int MAX_MISS_PENALTY = 16;

  function automatic int log2x(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  typedef struct packed {
    logic clk;
  } iu_clk_type;

  typedef struct packed {
    logic                  token_valid;
    logic                  request_valid;
    logic                  writeback_valid;
    logic [NTHREADIDMSB:0] tid;
    logic [31:0]           request_addr;
  } tm_mem_request_t;
endpackage

package libtm_cache;
  import libtm::*;

  localparam int MRQ_WAIT_W = log2x(MAX_MISS_PENALTY);

  typedef enum logic [1:0] {
    MRQ_IDLE = 2'd0,
    MRQ_WAIT = 2'd1
  } mrq_state_t;

  typedef struct packed {
    mrq_state_t            st;
    logic [MRQ_WAIT_W-1:0] cnt;
  } mrq_entry_t;
endpackage

// File: rtl/tm_mem_req_issuer_state_ram.sv
// Per-thread miss state RAM: one write port, async read, and the post-reset
// sweep that walks every entry back to IDLE.
module mrq_state_ram
  import libtm::*;
  import libtm_cache::*;
#(
  parameter int NT = NTHREAD
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [NTHREADIDMSB:0] waddr,
  input  mrq_entry_t            wdata,
  input  logic [NTHREADIDMSB:0] raddr,
  output mrq_entry_t            rdata,
  output logic                  init_busy
);
  localparam int AW = NTHREADIDMSB + 1;

  logic [AW-1:0] init_cnt;

  (* syn_ramstyle = "select_ram" *) mrq_entry_t mem [NT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_cnt  <= '0;
      init_busy <= 1'b1;
    end else if (init_busy) begin
      init_cnt <= init_cnt + AW'(1);
      if (init_cnt == AW'(NT-1)) init_busy <= 1'b0;
    end
  end

  // Storage has no reset; the sweep owns the write port until every entry is IDLE.
  always_ff @(posedge clk) begin
    if (init_busy)
      mem[init_cnt] <= '{st: MRQ_IDLE, cnt: '0};
    else if (we)
      mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/tm_mem_req_issuer.sv
// Per-thread miss-issue timing model: turns each thread token into a DRAM
// request or poll token and holds missing threads until the DRAM stall drops.
module tm_mem_req_issuer
  import libtm::*;
  import libtm_cache::*;
#(
  parameter int NT    = NTHREAD,
  parameter int STATW = 32
) (
  input  iu_clk_type            gclk,
  input  logic                  rst_n,
  input  logic                  tok_valid,
  input  logic [NTHREADIDMSB:0] tok_tid,
  input  logic                  miss_valid,
  input  logic                  miss_dirty,
  input  logic [31:0]           miss_addr,
  output tm_mem_request_t       dram_request,
  input  logic                  stay_stalled_for_dram,
  output logic                  resp_valid,
  output logic [NTHREADIDMSB:0] resp_tid,
  output logic                  resp_stall,
  output logic                  init_busy,
  output logic                  proto_err,
  output logic [STATW-1:0]      stat_miss,
  output logic [STATW-1:0]      stat_wb,
  output logic [STATW-1:0]      stat_stall
);
  logic clk;
  assign clk = gclk.clk;

  logic                  s2_vld, s2_miss, s2_dirty;
  logic [NTHREADIDMSB:0] s2_tid;
  logic [31:0]           s2_addr;

  logic                  fwd_vld;
  logic [NTHREADIDMSB:0] fwd_tid;
  mrq_entry_t            fwd_data;

  mrq_entry_t      rd_data, cur, nxt;
  tm_mem_request_t req;
  logic            stall, err2, inc_miss, inc_wb;

  mrq_state_ram #(.NT(NT)) u_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (s2_vld),
    .waddr     (s2_tid),
    .wdata     (nxt),
    .raddr     (s2_tid),
    .rdata     (rd_data),
    .init_busy (init_busy)
  );

  // Stage 1: register the token; tokens arriving during the sweep are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld   <= 1'b0;
      s2_tid   <= '0;
      s2_miss  <= 1'b0;
      s2_dirty <= 1'b0;
      s2_addr  <= '0;
    end else begin
      s2_vld   <= tok_valid && !init_busy;
      s2_tid   <= tok_tid;
      s2_miss  <= miss_valid;
      s2_dirty <= miss_dirty;
      s2_addr  <= miss_addr;
    end
  end

  // Last committed entry, so the read never depends on RAM write-through behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_vld  <= 1'b0;
      fwd_tid  <= '0;
      fwd_data <= '{st: MRQ_IDLE, cnt: '0};
    end else begin
      fwd_vld  <= s2_vld;
      fwd_tid  <= s2_tid;
      fwd_data <= nxt;
    end
  end

  always_comb begin
    cur      = (fwd_vld && fwd_tid == s2_tid) ? fwd_data : rd_data;
    nxt      = cur;
    req      = '0;
    stall    = 1'b0;
    err2     = 1'b0;
    inc_miss = 1'b0;
    inc_wb   = 1'b0;
    if (s2_vld) begin
      req.token_valid = 1'b1;
      req.tid         = s2_tid;
      case (cur.st)
        MRQ_WAIT: begin
          if (s2_miss) err2 = 1'b1;
          if (stay_stalled_for_dram) begin
            stall   = 1'b1;
            nxt.cnt = (cur.cnt == '1) ? cur.cnt : cur.cnt + MRQ_WAIT_W'(1);
            // Watchdog: a release this late means the DRAM model lost it.
            if (nxt.cnt == MRQ_WAIT_W'(MAX_MISS_PENALTY-1)) err2 = 1'b1;
          end else begin
            nxt = '{st: MRQ_IDLE, cnt: '0};
          end
        end
        default: begin
          if (s2_miss) begin
            req.request_valid   = 1'b1;
            req.writeback_valid = s2_dirty;
            req.request_addr    = s2_addr;
            nxt                 = '{st: MRQ_WAIT, cnt: '0};
            stall               = 1'b1;
            inc_miss            = 1'b1;
            inc_wb              = s2_dirty;
          end else begin
            nxt = '{st: MRQ_IDLE, cnt: '0};
          end
        end
      endcase
    end
  end

  assign dram_request = req;
  assign resp_valid   = s2_vld;
  assign resp_tid     = s2_vld ? s2_tid : '0;
  assign resp_stall   = stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      proto_err  <= 1'b0;
      stat_miss  <= '0;
      stat_wb    <= '0;
      stat_stall <= '0;
    end else begin
      if (err2 || (tok_valid && init_busy)) proto_err <= 1'b1;
      if (inc_miss) stat_miss  <= stat_miss + STATW'(1);
      if (inc_wb)   stat_wb    <= stat_wb + STATW'(1);
      if (stall)    stat_stall <= stat_stall + STATW'(1);
    end
  end
endmodule

// File: tb/tb_tm_mem_req_issuer.sv
// Scoreboard bench for tm_mem_req_issuer: directed tokens push expected
// responses, a negedge monitor pops and compares each presented response.
module tb_tm_mem_req_issuer;
  import libtm::*;

  typedef struct {
    logic [NTHREADIDMSB:0] tid;
    logic                  stall;
    logic                  req;
    logic                  wb;
    logic [31:0]           addr;
  } exp_t;

  logic                  clk = 1'b0;
  iu_clk_type            gclk;
  logic                  rst_n;
  logic                  tok_valid, miss_valid, miss_dirty, stay;
  logic [NTHREADIDMSB:0] tok_tid;
  logic [31:0]           miss_addr;
  tm_mem_request_t       dram_request;
  logic                  resp_valid, resp_stall, init_busy, proto_err;
  logic [NTHREADIDMSB:0] resp_tid;
  logic [31:0]           stat_miss, stat_wb, stat_stall;

  int   checks = 0;
  int   errors = 0;
  logic pend_stay = 1'b0;
  exp_t exp_q[$];

  assign gclk.clk = clk;
  always #5 clk = ~clk;

  tm_mem_req_issuer #(.NT(4), .STATW(32)) dut (
    .gclk                  (gclk),
    .rst_n                 (rst_n),
    .tok_valid             (tok_valid),
    .tok_tid               (tok_tid),
    .miss_valid            (miss_valid),
    .miss_dirty            (miss_dirty),
    .miss_addr             (miss_addr),
    .dram_request          (dram_request),
    .stay_stalled_for_dram (stay),
    .resp_valid            (resp_valid),
    .resp_tid              (resp_tid),
    .resp_stall            (resp_stall),
    .init_busy             (init_busy),
    .proto_err             (proto_err),
    .stat_miss             (stat_miss),
    .stat_wb               (stat_wb),
    .stat_stall            (stat_stall)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 32'(resp_tid), 32'hffff_ffff);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("resp_tid",   32'(resp_tid),   32'(e.tid));
        chk("req_tid",    32'(dram_request.tid), 32'(e.tid));
        chk("token_vld",  32'(dram_request.token_valid), 32'd1);
        chk("resp_stall", 32'(resp_stall), 32'(e.stall));
        chk("req_valid",  32'(dram_request.request_valid), 32'(e.req));
        chk("wb_valid",   32'(dram_request.writeback_valid), 32'(e.wb));
        if (e.req) chk("req_addr", dram_request.request_addr, e.addr);
      end
    end
  end

  // stay applies in the cycle after the token is presented (its stage-2 cycle).
  task automatic tok(input logic [NTHREADIDMSB:0] tid, input logic miss, input logic dirty,
                     input logic [31:0] addr, input logic st,
                     input logic e_stall, input logic e_req, input logic e_wb);
    exp_t e;
    e.tid = tid; e.stall = e_stall; e.req = e_req; e.wb = e_wb; e.addr = addr;
    exp_q.push_back(e);
    @(posedge clk); #1;
    tok_valid = 1'b1; tok_tid = tid; miss_valid = miss; miss_dirty = dirty; miss_addr = addr;
    stay = pend_stay; pend_stay = st;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      tok_valid = 1'b0; miss_valid = 1'b0; miss_dirty = 1'b0;
      stay = pend_stay; pend_stay = 1'b0;
    end
  endtask

  task automatic wait_init();
    int n = 0;
    while (init_busy === 1'b1 && n < 50) begin
      @(negedge clk); n++;
    end
    chk("init_done", 32'(init_busy), 32'd0);
  endtask

  task automatic reset_sync();
    @(posedge clk); #1;
    rst_n = 1'b0; tok_valid = 1'b0; stay = 1'b0; pend_stay = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_init();
  endtask

  initial begin
    int busy_n;
    rst_n = 1'b0; tok_valid = 1'b0; tok_tid = '0; miss_valid = 1'b0;
    miss_dirty = 1'b0; miss_addr = '0; stay = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_init_busy", 32'(init_busy), 32'd1);
    chk("rst_resp_vld",  32'(resp_valid), 32'd0);
    chk("rst_resp_stall",32'(resp_stall), 32'd0);
    chk("rst_dram_req",  32'(dram_request != '0), 32'd0);
    chk("rst_proto_err", 32'(proto_err), 32'd0);
    chk("rst_stat_miss", stat_miss, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    busy_n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (init_busy !== 1'b1) break;
      busy_n++;
    end
    chk("init_busy_cycles", 32'(busy_n), 32'd4);

    // All entries IDLE after the sweep.
    for (int t = 0; t < 4; t++) tok(2'(t), 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    chk("init_stat_stall", stat_stall, 32'd0);

    // Clean miss, three held tokens, release.
    tok(2'd2, 1'b1, 1'b0, 32'h1000, 1'b1, 1'b1, 1'b1, 1'b0);
    tok(2'd2, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    tok(2'd2, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    tok(2'd2, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    tok(2'd2, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    chk("clean_stat_miss",  stat_miss,  32'd1);
    chk("clean_stat_stall", stat_stall, 32'd4);
    chk("clean_stat_wb",    stat_wb,    32'd0);

    // Dirty miss.
    tok(2'd3, 1'b1, 1'b1, 32'h2040, 1'b1, 1'b1, 1'b1, 1'b1);
    tok(2'd3, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    chk("dirty_stat_wb",    stat_wb,    32'd1);
    chk("dirty_stat_miss",  stat_miss,  32'd2);
    chk("dirty_stat_stall", stat_stall, 32'd5);

    // Same tid on consecutive cycles must see WAIT.
    tok(2'd0, 1'b1, 1'b0, 32'h3000, 1'b1, 1'b1, 1'b1, 1'b0);
    tok(2'd0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    tok(2'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    chk("b2b_stat_stall", stat_stall, 32'd7);
    chk("b2b_proto_err",  32'(proto_err), 32'd0);

    // Miss while already in WAIT is ignored and flagged.
    tok(2'd1, 1'b1, 1'b0, 32'h4000, 1'b1, 1'b1, 1'b1, 1'b0);
    tok(2'd1, 1'b1, 1'b1, 32'h5000, 1'b1, 1'b1, 1'b0, 1'b0);
    tok(2'd1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    chk("illegal_proto_err", 32'(proto_err), 32'd1);
    chk("illegal_stat_miss", stat_miss, 32'd4);
    chk("illegal_stat_wb",   stat_wb,   32'd1);

    // Lost-release watchdog on a fresh run.
    reset_sync();
    chk("wd_err_cleared", 32'(proto_err), 32'd0);
    tok(2'd2, 1'b1, 1'b0, 32'h6000, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 14; k++) tok(2'd2, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);
    chk("wd_not_yet", 32'(proto_err), 32'd0);
    tok(2'd2, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);
    chk("wd_proto_err", 32'(proto_err), 32'd1);
    chk("wd_stat_stall", stat_stall, 32'd16);
    tok(2'd2, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);

    // Reset while tid 1 is waiting.
    tok(2'd1, 1'b1, 1'b0, 32'h7000, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(2);
    @(negedge clk); #2 rst_n = 1'b0;
    tok_valid = 1'b0; stay = 1'b0; pend_stay = 1'b0;
    #1;
    chk("mid_rst_busy",      32'(init_busy),  32'd1);
    chk("mid_rst_resp_vld",  32'(resp_valid), 32'd0);
    chk("mid_rst_stat_miss", stat_miss,       32'd0);
    chk("mid_rst_proto_err", 32'(proto_err),  32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    tok_valid = 1'b1; tok_tid = 2'd1; miss_valid = 1'b1; miss_addr = 32'h8000;
    idle(1);
    wait_init();
    chk("sweep_tok_err", 32'(proto_err), 32'd1);
    tok(2'd1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    chk("post_rst_stat_stall", stat_stall, 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
